// File: rtl/neuron_wt_loader.sv
// Weight loader for one neuron: collects a serial frame of NUM_IP signed weights into a
// shadow buffer, then asserts update_wts for exactly NUM_IP enabled cycles to load the neuron.
module neuron_wt_loader #(
  parameter int IP_DATA_WIDTH = 8,
  parameter int NUM_IP        = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic signed [2*IP_DATA_WIDTH-1:0]      s_data,
  input  logic                                   s_last,
  input  logic                                   freeze,
  output logic [NUM_IP-1:0][2*IP_DATA_WIDTH-1:0] wt_out,
  output logic                                   update_wts,
  output logic                                   busy,
  output logic                                   wt_done,
  output logic                                   len_err
);

  localparam int CW = $clog2(NUM_IP);

  localparam logic [0:0]    FILL       = 1'b0;
  localparam logic [0:0]    COMMIT     = 1'b1;
  localparam logic [CW-1:0] FILL_LAST  = CW'(NUM_IP - 1);
  localparam logic [CW-1:0] FILL_ONE   = CW'(1);
  localparam logic [CW-1:0] FILL_ZERO  = CW'(0);
  localparam logic [CW:0]   COMMIT_END = (CW+1)'(NUM_IP);
  localparam logic [CW:0]   COMMIT_ZERO = (CW+1)'(0);

  logic [0:0]    state_r;
  logic [CW-1:0] fill_cnt_r;
  logic [CW:0]   commit_cnt_r;

  logic [0:0]    state_s;
  logic [CW-1:0] fill_cnt_s;
  logic [CW:0]   commit_cnt_s;
  logic [CW:0]   commit_sum_s;
  logic          s_ready_s;
  logic          update_wts_s;
  logic          busy_s;
  logic          wt_done_s;
  logic          len_err_s;
  logic          wr_en_s;

  // Next-state and next-output decode; completion is detected one cycle early so
  // update_wts drops and wt_done rises in the same registered cycle.
  always_comb begin
    state_s      = state_r;
    fill_cnt_s   = fill_cnt_r;
    commit_cnt_s = commit_cnt_r;
    s_ready_s    = s_ready;
    update_wts_s = 1'b0;
    busy_s       = busy;
    wt_done_s    = 1'b0;
    len_err_s    = 1'b0;
    wr_en_s      = 1'b0;
    commit_sum_s = commit_cnt_r + {{CW{1'b0}}, update_wts};
    case (state_r)
      FILL: begin
        if (s_valid && s_ready) begin
          wr_en_s = 1'b1;
          if ((fill_cnt_r == FILL_LAST) && s_last) begin
            state_s    = COMMIT;
            s_ready_s  = 1'b0;
            busy_s     = 1'b1;
            fill_cnt_s = FILL_ZERO;
          end else if ((fill_cnt_r == FILL_LAST) || s_last) begin
            len_err_s  = 1'b1;
            fill_cnt_s = FILL_ZERO;
          end else begin
            fill_cnt_s = fill_cnt_r + FILL_ONE;
          end
        end else begin
          fill_cnt_s = fill_cnt_r;
        end
      end
      COMMIT: begin
        if (commit_sum_s == COMMIT_END) begin
          state_s      = FILL;
          s_ready_s    = 1'b1;
          busy_s       = 1'b0;
          wt_done_s    = 1'b1;
          fill_cnt_s   = FILL_ZERO;
          commit_cnt_s = COMMIT_ZERO;
        end else begin
          commit_cnt_s = commit_sum_s;
          update_wts_s = !freeze;
        end
      end
      default: begin
        state_s      = FILL;
        s_ready_s    = 1'b1;
        busy_s       = 1'b0;
        fill_cnt_s   = FILL_ZERO;
        commit_cnt_s = COMMIT_ZERO;
      end
    endcase
  end

  // Control state and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= FILL;
      fill_cnt_r   <= FILL_ZERO;
      commit_cnt_r <= COMMIT_ZERO;
      s_ready      <= 1'b1;
      update_wts   <= 1'b0;
      busy         <= 1'b0;
      wt_done      <= 1'b0;
      len_err      <= 1'b0;
    end else begin
      state_r      <= state_s;
      fill_cnt_r   <= fill_cnt_s;
      commit_cnt_r <= commit_cnt_s;
      s_ready      <= s_ready_s;
      update_wts   <= update_wts_s;
      busy         <= busy_s;
      wt_done      <= wt_done_s;
      len_err      <= len_err_s;
    end
  end

  // Shadow buffer; written only by accepted beats, so it is frozen during COMMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wt_out <= '0;
    end else if (wr_en_s) begin
      wt_out[fill_cnt_r] <= s_data;
    end else begin
      wt_out <= wt_out;
    end
  end

endmodule

// File: tb/tb_neuron_wt_loader.sv
// Bench for neuron_wt_loader: frame-level reference model plus a neuron pointer model
// that captures wt_out[ptr] on every update_wts cycle.
module tb_neuron_wt_loader;

  localparam int IPW = 8;
  localparam int NIP = 8;
  localparam int W   = 2*IPW;
  localparam int CW  = $clog2(NIP);

  logic                  clk;
  logic                  rst;
  logic                  s_valid;
  logic                  s_ready;
  logic signed [W-1:0]   s_data;
  logic                  s_last;
  logic                  freeze;
  logic [NIP-1:0][W-1:0] wt_out;
  logic                  update_wts;
  logic                  busy;
  logic                  wt_done;
  logic                  len_err;

  int vectors = 0;
  int miscompares = 0;

  logic [NIP-1:0][W-1:0] nm_vec = '0;
  logic [CW-1:0]         nm_ptr = '0;
  int                    hi_cnt = 0;

  neuron_wt_loader #(.IP_DATA_WIDTH(IPW), .NUM_IP(NIP)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .freeze(freeze), .wt_out(wt_out), .update_wts(update_wts),
    .busy(busy), .wt_done(wt_done), .len_err(len_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Neuron model: write pointer advances once per update_wts cycle, reset together with the loader.
  always @(posedge clk) begin
    if (rst) begin
      nm_ptr <= '0;
    end else if (update_wts) begin
      nm_vec[nm_ptr] <= wt_out[nm_ptr];
      nm_ptr <= nm_ptr + CW'(1);
      hi_cnt <= hi_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; freeze = 1'b0;
    tick(); tick();
    vectors++;
    if (s_ready !== 1'b1 || update_wts !== 1'b0 || busy !== 1'b0 || wt_done !== 1'b0 || len_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: rdy=%b upd=%b busy=%b done=%b lerr=%b expected 1 0 0 0 0",
               s_ready, update_wts, busy, wt_done, len_err);
    end
    vectors++;
    if (wt_out !== '0) begin
      miscompares++;
      $display("FAIL reset_wt: got %h expected 0", wt_out);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_commit(input bit ramp, input int frz_start, input int frz_len, input bit rnd_frz);
    logic [W-1:0] q[$];
    logic [NIP-1:0][W-1:0] exp_vec;
    logic [W-1:0] w;
    int remaining;
    int hi0;
    logic prev_frz, exp_upd, exp_done, finished;
    exp_vec = '0;
    for (int i = 0; i < NIP; i++) begin
      w = ramp ? W'(i - NIP/2) : W'($urandom);
      q.push_back(w);
      exp_vec = {w, exp_vec[NIP-1:1]};
    end
    hi0 = hi_cnt;
    for (int i = 0; i < NIP; i++) begin
      s_valid = 1'b1; s_data = q[i]; s_last = (i == NIP-1);
      vectors++;
      if (s_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL fill_ready: beat %0d s_ready=%b expected 1", i, s_ready);
      end
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    vectors++;
    if (busy !== 1'b1 || s_ready !== 1'b0 || update_wts !== 1'b0 || wt_out !== exp_vec) begin
      miscompares++;
      $display("FAIL commit_entry: busy=%b rdy=%b upd=%b wt=%h expected 1 0 0 %h",
               busy, s_ready, update_wts, wt_out, exp_vec);
    end
    remaining = NIP; prev_frz = 1'b0; finished = 1'b0;
    for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
      tick();
      if (remaining == 0) begin
        exp_upd = 1'b0; exp_done = 1'b1; finished = 1'b1;
      end else begin
        exp_upd = !prev_frz; exp_done = 1'b0;
        if (exp_upd) remaining--;
      end
      vectors++;
      if (update_wts !== exp_upd || wt_done !== exp_done) begin
        miscompares++;
        $display("FAIL commit_seq: cyc %0d upd=%b done=%b expected %b %b", cyc, update_wts, wt_done, exp_upd, exp_done);
      end
      vectors++;
      if (wt_out !== exp_vec || busy !== !finished || s_ready !== finished) begin
        miscompares++;
        $display("FAIL commit_hold: cyc %0d wt=%h busy=%b rdy=%b expected %h %b %b",
                 cyc, wt_out, busy, s_ready, exp_vec, !finished, finished);
      end
      if (rnd_frz) freeze = ($urandom_range(0, 2) == 0);
      else         freeze = (cyc >= frz_start && cyc < frz_start + frz_len);
      prev_frz = freeze;
    end
    freeze = 1'b0;
    vectors++;
    if (!finished) begin
      miscompares++;
      $display("FAIL commit_timeout: wt_done never expected-seen, remaining=%0d expected 0", remaining);
    end
    vectors++;
    if (hi_cnt - hi0 !== NIP || nm_vec !== exp_vec || nm_ptr !== {CW{1'b0}}) begin
      miscompares++;
      $display("FAIL neuron_mem: highs=%0d mem=%h ptr=%0d expected %0d %h 0", hi_cnt - hi0, nm_vec, nm_ptr, NIP, exp_vec);
    end
    tick();
    vectors++;
    if (wt_done !== 1'b0 || update_wts !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse: done=%b upd=%b expected 0 0", wt_done, update_wts);
    end
  endtask

  task automatic test_len_err_short();
    int hi0;
    hi0 = hi_cnt;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = W'($urandom); s_last = (i == 4);
      vectors++;
      if (s_ready !== 1'b1 || len_err !== 1'b0) begin
        miscompares++;
        $display("FAIL short_fill: beat %0d rdy=%b lerr=%b expected 1 0", i, s_ready, len_err);
      end
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    vectors++;
    if (len_err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1 || update_wts !== 1'b0) begin
      miscompares++;
      $display("FAIL short_err: lerr=%b busy=%b rdy=%b upd=%b expected 1 0 1 0", len_err, busy, s_ready, update_wts);
    end
    tick();
    vectors++;
    if (len_err !== 1'b0 || busy !== 1'b0 || hi_cnt !== hi0) begin
      miscompares++;
      $display("FAIL short_after: lerr=%b busy=%b highs=%0d expected 0 0 0", len_err, busy, hi_cnt - hi0);
    end
  endtask

  task automatic test_len_err_long();
    for (int i = 0; i < NIP; i++) begin
      s_valid = 1'b1; s_data = W'($urandom); s_last = 1'b0;
      vectors++;
      if (s_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL long_fill: beat %0d rdy=%b expected 1", i, s_ready);
      end
      tick();
    end
    s_valid = 1'b0;
    vectors++;
    if (len_err !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL long_err: lerr=%b rdy=%b busy=%b expected 1 1 0", len_err, s_ready, busy);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (busy !== 1'b0 || update_wts !== 1'b0 || len_err !== 1'b0 || s_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL long_idle: cyc %0d busy=%b upd=%b lerr=%b rdy=%b expected 0 0 0 1",
                 i, busy, update_wts, len_err, s_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int P = 2*NIP + 1;
    logic [W-1:0] q[$];
    logic [NIP-1:0][W-1:0] f1, f2;
    logic [W-1:0] w;
    logic exp_rdy, exp_done, exp_upd;
    int k, ph;
    f1 = '0; f2 = '0; k = 0;
    for (int i = 0; i < 2*NIP; i++) begin
      w = W'($urandom);
      q.push_back(w);
      if (i < NIP) f1 = {w, f1[NIP-1:1]};
      else         f2 = {w, f2[NIP-1:1]};
    end
    for (int c = 0; c < 2*P + 1; c++) begin
      ph = c % P;
      exp_rdy  = (ph < NIP);
      exp_upd  = (ph > NIP);
      exp_done = (ph == 0) && (c > 0);
      if (k < 2*NIP) begin
        s_valid = 1'b1; s_data = q[k]; s_last = ((k % NIP) == NIP-1);
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      vectors++;
      if (s_ready !== exp_rdy || wt_done !== exp_done || update_wts !== exp_upd) begin
        miscompares++;
        $display("FAIL b2b_seq: c %0d rdy=%b done=%b upd=%b expected %b %b %b",
                 c, s_ready, wt_done, update_wts, exp_rdy, exp_done, exp_upd);
      end
      if (c == P || c == 2*P) begin
        vectors++;
        if (nm_vec !== ((c == P) ? f1 : f2)) begin
          miscompares++;
          $display("FAIL b2b_mem: c %0d got %h expected %h", c, nm_vec, (c == P) ? f1 : f2);
        end
      end
      if (exp_rdy && k < 2*NIP) k++;
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset_mid_commit();
    for (int i = 0; i < NIP; i++) begin
      s_valid = 1'b1; s_data = W'($urandom) | W'(1); s_last = (i == NIP-1);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (update_wts !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rmc_third: upd=%b busy=%b expected 1 1", update_wts, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (update_wts !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0 || wt_out !== '0 || wt_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rmc_reset: upd=%b rdy=%b busy=%b wt=%h done=%b expected 0 1 0 0 0",
               update_wts, s_ready, busy, wt_out, wt_done);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if (wt_done !== 1'b0 || update_wts !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rmc_after: cyc %0d done=%b upd=%b busy=%b expected 0 0 0", i, wt_done, update_wts, busy);
      end
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; freeze = 1'b0;
    test_reset();
    test_commit(1'b1, 0, 0, 1'b0);
    test_commit(1'b1, 2, 3, 1'b0);
    test_len_err_short();
    test_commit(1'b0, 0, 0, 1'b0);
    test_len_err_long();
    test_commit(1'b0, 0, 0, 1'b1);
    test_commit(1'b0, 5, 4, 1'b0);
    test_back_to_back();
    test_reset_mid_commit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/neuron_wt_loader.md
Name: neuron_wt_loader

Overview:
- Upstream weight-delivery stage for one neuron instance.
- Accepts a serial valid/ready stream of exactly NUM_IP signed weights per frame and buffers them in a shadow register array.
- Then drives the neuron's parallel weight bus with update_wts held high for exactly NUM_IP consecutive enabled cycles. The neuron's internal write pointer advances once per high cycle, so it ends back at index 0.
- Used for pretrain load and for backprop weight write-back.

Parameters:
- IP_DATA_WIDTH, 8, base data width; weights are 2*IP_DATA_WIDTH bits signed.
- NUM_IP, 8, weights per frame (= neuron inputs); must be a power of two, >=2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- s_valid  input  1  weight beat valid
- s_ready  output  1  loader can accept a beat
- s_data  input  2*IP_DATA_WIDTH  signed weight; beat k is weight index k
- s_last  input  1  marks final beat of frame
- freeze  input  1  pause commit (e.g. neuron MAC sampling); no effect outside COMMIT
- wt_out  output  [NUM_IP-1:0] x 2*IP_DATA_WIDTH  to neuron wt_in; shadow buffer contents
- update_wts  output  1  to neuron update_wts
- busy  output  1  high in COMMIT
- wt_done  output  1  one-cycle pulse, frame committed
- len_err  output  1  one-cycle pulse, malformed frame discarded

Behaviour:
- State encoding: FILL, COMMIT; all outputs registered.
- Reset:
  - state=FILL, fill_cnt=0, commit_cnt=0.
  - All shadow entries=0.
  - s_ready=1, update_wts=0, busy=0, wt_done=0, len_err=0.
  - Reset mid-commit drops update_wts the next cycle. The neuron pointer is then out of phase, so the system must reset both blocks together.
- FILL:
  - s_ready=1.
  - A beat transfers on s_valid&&s_ready; it writes shadow[fill_cnt]=s_data, and fill_cnt increments.
  - Beat with fill_cnt==NUM_IP-1 and s_last=1: goes to COMMIT next cycle; s_ready=0 from that cycle.
  - Beat with s_last=1 and fill_cnt<NUM_IP-1, or fill_cnt==NUM_IP-1 and s_last=0:
    - len_err pulses the next cycle; fill_cnt=0; stay in FILL.
    - Shadow entries are not cleared; the next frame overwrites them.
  - s_valid low: no change; no timeout.
- COMMIT:
  - busy=1; s_ready=0; wt_out is stable throughout (shadow is not writable).
  - update_wts = !freeze, registered, so it follows freeze with 1-cycle latency.
  - First update_wts high cycle is the cycle after COMMIT entry (if freeze is low in the entry cycle).
  - commit_cnt increments on every cycle update_wts is high.
  - When commit_cnt reaches NUM_IP: update_wts=0, wt_done=1 for one cycle, state=FILL, s_ready=1, fill_cnt=0, commit_cnt=0, all in the same cycle.
  - update_wts is high for exactly NUM_IP cycles per frame, never more, regardless of the freeze pattern.
- Throughput: best case NUM_IP accept cycles + 1 transition cycle + NUM_IP commit cycles per frame. A new frame's first beat can be accepted in the wt_done cycle.
- Arithmetic:
  - fill_cnt is $clog2(NUM_IP) bits; commit_cnt is $clog2(NUM_IP)+1 bits.
  - Data is passed through unmodified, sign preserved; no saturation.
- Frames in flight: at most one. No beat is ever dropped silently; beats offered during COMMIT are backpressured.

Test Plan:
- Reset then a frame of 8 beats, values -4,-3,...,3, back-to-back with s_last on beat 7 -> wt_out = {3,2,...,-4} (index0 = -4); update_wts high exactly 8 consecutive cycles starting 2 cycles after beat 7; wt_done one cycle after the last high; neuron model wt_mem matches.
- Same frame with freeze high for 3 cycles mid-commit -> update_wts low for those 3 cycles (1-cycle lag); total high count still 8; wt_out unchanged throughout; wt_done after the 8th high.
- s_last on beat 4 -> len_err pulse; no update_wts; a following valid 8-beat frame commits correctly, and no data from the bad frame appears at indices 0-7.
- 8 beats without s_last -> len_err after beat 7; s_ready stays 1; busy never asserts.
- s_valid held high continuously with 2 frames queued -> s_ready low during COMMIT; second frame's beat 0 accepted in the wt_done cycle; both frames' values reach the neuron in order.
- rst asserted on the 3rd update_wts cycle -> next cycle update_wts=0, s_ready=1, busy=0, wt_out all 0, no wt_done pulse.
